// File: rtl/mem_bus_arbiter.sv
// Arbiter for the single SRAM-like memory port shared by instruction fetch and data access.
// Runs one req/addr_ok/data_ok transaction at a time; data wins over fetch when both request together.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ok,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        stall_f,
    output logic        stall_m
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        bus_req_nxt, bus_wr_nxt;
    logic [1:0]  bus_size_nxt;
    logic [31:0] bus_addr_nxt, bus_wdata_nxt;
    logic [31:0] rdata_q, rdata_nxt;
    logic        inst_ok_nxt, data_ok_nxt;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        bus_req_nxt   = bus_req;
        bus_wr_nxt    = bus_wr;
        bus_size_nxt  = bus_size;
        bus_addr_nxt  = bus_addr;
        bus_wdata_nxt = bus_wdata;
        rdata_nxt     = rdata_q;
        inst_ok_nxt   = 1'b0;
        data_ok_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (data_req) begin
                    owner_nxt     = OWNER_DATA;
                    bus_req_nxt   = 1'b1;
                    bus_wr_nxt    = data_wr;
                    bus_size_nxt  = data_size;
                    bus_addr_nxt  = data_addr;
                    bus_wdata_nxt = data_wdata;
                    state_nxt     = ADDR;
                end else if (inst_req) begin
                    owner_nxt     = OWNER_INST;
                    bus_req_nxt   = 1'b1;
                    bus_wr_nxt    = 1'b0;
                    bus_size_nxt  = 2'd2;
                    bus_addr_nxt  = inst_addr;
                    bus_wdata_nxt = '0;
                    state_nxt     = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    bus_req_nxt = 1'b0;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                if (bus_data_ok) begin
                    // Write acks carry no data, so the return register reads zero for stores.
                    rdata_nxt   = bus_wr ? 32'h0 : bus_rdata;
                    inst_ok_nxt = (owner == OWNER_INST);
                    data_ok_nxt = (owner == OWNER_DATA);
                    state_nxt   = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWNER_INST;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_size  <= 2'd0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            rdata_q   <= 32'h0;
            inst_ok   <= 1'b0;
            data_ok   <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            bus_req   <= bus_req_nxt;
            bus_wr    <= bus_wr_nxt;
            bus_size  <= bus_size_nxt;
            bus_addr  <= bus_addr_nxt;
            bus_wdata <= bus_wdata_nxt;
            rdata_q   <= rdata_nxt;
            inst_ok   <= inst_ok_nxt;
            data_ok   <= data_ok_nxt;
        end
    end

    // Both requesters see the shared return register; only their ok pulse qualifies it.
    assign inst_rdata = rdata_q;
    assign data_rdata = rdata_q;

    assign stall_f = inst_req & ~inst_ok;
    assign stall_m = data_req & ~data_ok;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: requester tasks, a bus responder model and
// scoreboard queues of expected bus transactions and expected completions.
module tb_mem_bus_arbiter;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] resp;
    } bus_exp_t;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
    } ok_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, data_req, data_wr;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [1:0]  data_size;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_ok, data_ok;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_addr_ok, bus_data_ok;
    logic        stall_f, stall_m;

    int n_cmp  = 0;
    int n_fail = 0;

    bus_exp_t exp_bus[$];
    ok_exp_t  exp_ok[$];

    bit bus_auto = 1'b1;
    int addr_dly = 0;
    int data_dly = 0;
    int lat_d, lat_i;

    mem_bus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_ok     (inst_ok),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_ok     (data_ok),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .stall_f     (stall_f),
        .stall_m     (stall_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_txn(input bit is_data, input bit wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] resp);
        bus_exp_t b;
        ok_exp_t  o;
        b.wr    = is_data ? wr : 1'b0;
        b.size  = is_data ? size : 2'd2;
        b.addr  = addr;
        b.wdata = is_data ? wdata : 32'h0;
        b.resp  = resp;
        o.owner = is_data;
        o.rdata = b.wr ? 32'h0 : resp;
        exp_bus.push_back(b);
        exp_ok.push_back(o);
    endtask

    // Requester: raise req in cycle 0, hold until ok is sampled, then drop it.
    task automatic do_req(input bit is_data, input bit wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, output int lat);
        logic ok_now;
        @(posedge clk); #1;
        if (is_data) begin
            data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
        end else begin
            inst_req = 1'b1; inst_addr = addr;
        end
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            ok_now = is_data ? data_ok : inst_ok;
            if (ok_now) begin
                lat = c;
                check(is_data ? "stall_m_at_ok" : "stall_f_at_ok", is_data ? stall_m : stall_f, 0);
                break;
            end
            check(is_data ? "stall_m" : "stall_f", is_data ? stall_m : stall_f, 1);
        end
        if (lat < 0) check(is_data ? "data_timeout" : "inst_timeout", 0, 1);
        @(posedge clk); #1;
        if (is_data) data_req = 1'b0; else inst_req = 1'b0;
        @(negedge clk);
        check(is_data ? "data_ok_one_cycle" : "inst_ok_one_cycle", is_data ? data_ok : inst_ok, 0);
    endtask

    // Completion scoreboard: every ok pulse must match the oldest expected completion.
    ok_exp_t mon_e;
    always @(negedge clk) begin
        if (!reset && (inst_ok || data_ok)) begin
            check("ok_onehot", {31'h0, inst_ok & data_ok}, 0);
            if (exp_ok.size() == 0) begin
                check("unexpected_ok", 1, 0);
            end else begin
                mon_e = exp_ok.pop_front();
                check("ok_owner", {31'h0, data_ok}, {31'h0, mon_e.owner});
                check(mon_e.owner ? "data_rdata" : "inst_rdata",
                      mon_e.owner ? data_rdata : inst_rdata, mon_e.rdata);
            end
        end
    end

    // Bus responder with programmable addr_ok / data_ok delays; checks presented fields.
    initial begin
        int       a_cnt, d_cnt;
        bit       d_pending;
        bus_exp_t cur;
        a_cnt = 0; d_cnt = 0; d_pending = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus_auto) begin
                bus_addr_ok = 1'b0;
                bus_data_ok = 1'b0;
                if (reset) begin
                    a_cnt = 0; d_pending = 1'b0;
                end else if (d_pending) begin
                    check("bus_req_low_in_wait", {31'h0, bus_req}, 0);
                    if (d_cnt >= data_dly) begin
                        bus_data_ok = 1'b1; bus_rdata = cur.resp; d_pending = 1'b0;
                    end else begin
                        d_cnt++;
                    end
                end else if (bus_req) begin
                    if (exp_bus.size() == 0) begin
                        check("unexpected_bus_req", 1, 0);
                    end else begin
                        check("bus_wr",    {31'h0, bus_wr},   {31'h0, exp_bus[0].wr});
                        check("bus_size",  {30'h0, bus_size}, {30'h0, exp_bus[0].size});
                        check("bus_addr",  bus_addr,  exp_bus[0].addr);
                        check("bus_wdata", bus_wdata, exp_bus[0].wdata);
                        if (a_cnt >= addr_dly) begin
                            bus_addr_ok = 1'b1; a_cnt = 0; cur = exp_bus.pop_front();
                            d_pending = 1'b1; d_cnt = 0;
                        end else begin
                            a_cnt++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h0000_0040;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;

        // Reset values; stall_f follows inst_req even while reset is held.
        @(negedge clk); @(negedge clk);
        check("rst_bus_req",   {31'h0, bus_req}, 0);
        check("rst_bus_addr",  bus_addr, 0);
        check("rst_bus_size",  {30'h0, bus_size}, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_inst_ok",   {31'h0, inst_ok}, 0);
        check("rst_data_ok",   {31'h0, data_ok}, 0);
        check("rst_rdata",     inst_rdata, 0);
        check("rst_stall_f",   {31'h0, stall_f}, 1);
        check("rst_stall_m",   {31'h0, stall_m}, 0);
        @(posedge clk); #1;
        inst_req = 1'b0; reset = 1'b0;

        // Single load, minimum latency.
        expect_txn(1, 0, 2'd2, 32'h8000_0004, 32'h0, 32'h1234_5678);
        do_req(1, 0, 2'd2, 32'h8000_0004, 32'h0, lat_d);
        check("load_latency", lat_d, 3);

        // Simultaneous requests: data first, fetch granted after DONE.
        expect_txn(1, 0, 2'd2, 32'h8000_0010, 32'h0, 32'hCAFE_0001);
        expect_txn(0, 0, 2'd2, 32'h0000_0100, 32'h0, 32'h2400_0001);
        fork
            do_req(1, 0, 2'd2, 32'h8000_0010, 32'h0, lat_d);
            do_req(0, 0, 2'd2, 32'h0000_0100, 32'h0, lat_i);
        join
        check("simul_data_latency", lat_d, 3);
        check("simul_inst_latency", lat_i, 7);

        // Store word with wait states; write ack returns zero data.
        addr_dly = 3; data_dly = 2;
        expect_txn(1, 1, 2'd2, 32'h8000_0100, 32'hA5A5_5A5A, 32'hDEAD_BEEF);
        do_req(1, 1, 2'd2, 32'h8000_0100, 32'hA5A5_5A5A, lat_d);
        check("wait_store_latency", lat_d, 8);
        addr_dly = 0; data_dly = 0;

        // Byte store at an odd address; wdata passed as given.
        expect_txn(1, 1, 2'd0, 32'h1000_0003, 32'hAB00_0000, 32'h0);
        do_req(1, 1, 2'd0, 32'h1000_0003, 32'hAB00_0000, lat_d);
        check("byte_store_latency", lat_d, 3);

        // Spurious bus strobes in IDLE and ADDR, driven by hand.
        bus_auto = 1'b0;
        @(posedge clk); #1;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0020;
        begin
            ok_exp_t o;
            o.owner = 1'b1; o.rdata = 32'h0F0F_0F0F;
            exp_ok.push_back(o);
        end
        @(negedge clk);
        check("spur_idle_no_ok", {31'h0, data_ok | inst_ok}, 0);
        @(posedge clk); #1;                       // cycle 1: ADDR, data_ok still strobing
        @(negedge clk);
        check("spur_addr_bus_req", {31'h0, bus_req}, 1);
        check("spur_addr_bus_addr", bus_addr, 32'h8000_0020);
        @(posedge clk); #1;                       // cycle 2: still ADDR, accept address
        bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
        @(negedge clk);
        check("spur_still_addr", {31'h0, bus_req}, 1);
        check("spur_no_ok", {31'h0, data_ok}, 0);
        @(posedge clk); #1;                       // cycle 3: WAIT
        bus_addr_ok = 1'b0;
        @(negedge clk);
        check("spur_wait_bus_req", {31'h0, bus_req}, 0);
        @(posedge clk); #1;                       // cycle 4: data returns
        bus_data_ok = 1'b1; bus_rdata = 32'h0F0F_0F0F;
        @(negedge clk);
        check("spur_ok_not_early", {31'h0, data_ok}, 0);
        @(posedge clk); #1;                       // cycle 5: DONE
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        check("spur_ok_pulse", {31'h0, data_ok}, 1);
        @(posedge clk); #1;
        data_req = 1'b0;
        @(negedge clk);
        check("spur_ok_dropped", {31'h0, data_ok}, 0);
        bus_auto = 1'b1;

        // Reset asserted during WAIT, then a clean minimum-latency fetch.
        data_dly = 10;
        expect_txn(0, 0, 2'd2, 32'h0000_0200, 32'h0, 32'h1111_2222);
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'h0000_0200;
        @(posedge clk); @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("pre_rst_bus_addr", bus_addr, 32'h0000_0200);
        #2 reset = 1'b1;
        #1;
        check("async_rst_bus_req",  {31'h0, bus_req}, 0);
        check("async_rst_bus_addr", bus_addr, 0);
        check("async_rst_bus_size", {30'h0, bus_size}, 0);
        check("async_rst_inst_ok",  {31'h0, inst_ok}, 0);
        check("async_rst_stall_f",  {31'h0, stall_f}, 1);
        inst_req = 1'b0;
        exp_ok.delete();
        exp_bus.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        data_dly = 0;
        expect_txn(0, 0, 2'd2, 32'h0000_0300, 32'h0, 32'h3C08_BFC0);
        do_req(0, 0, 2'd2, 32'h0000_0300, 32'h0, lat_i);
        check("post_rst_fetch_latency", lat_i, 3);

        repeat (3) @(posedge clk);
        check("exp_ok_drained",  exp_ok.size(), 0);
        check("exp_bus_drained", exp_bus.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single SRAM-like memory port between instruction fetch (IF) and data access (MEM stage loads/stores), sequencing one transaction at a time over a req/addr_ok/data_ok handshake. It returns read data and a one-cycle completion pulse to the granted requester. It also produces the pipeline stall signals that freeze IF and MEM while their access is outstanding. The block sits between the pipeline front/MEM stage and the external memory bus.

## Interface
- No parameters.
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- inst_req  in  1  fetch request; held high until inst_ok
- inst_addr  in  32  fetch address (word aligned)
- inst_rdata  out  32  fetched word, valid while inst_ok=1
- inst_ok  out  1  one-cycle completion pulse for fetch
- data_req  in  1  MEM-stage request; held high until data_ok
- data_wr  in  1  1=store, 0=load
- data_size  in  2  0=byte, 1=half, 2=word
- data_addr  in  32  byte address
- data_wdata  in  32  store data (already lane-aligned by requester)
- data_rdata  out  32  load word, valid while data_ok=1
- data_ok  out  1  one-cycle completion pulse for data
- bus_req  out  1  bus request, held until bus_addr_ok
- bus_wr, bus_size, bus_addr, bus_wdata  out  1/2/32/32  registered copy of granted request
- bus_addr_ok  in  1  bus accepted address this cycle
- bus_data_ok  in  1  bus returns read data / write ack this cycle
- bus_rdata  in  32  read data, valid with bus_data_ok
- stall_f  out  1  inst_req & ~inst_ok
- stall_m  out  1  data_req & ~data_ok

## Operation
- States: IDLE, ADDR, WAIT, DONE; 1-bit owner register (0=inst, 1=data).
- IDLE: if data_req -> latch data request (wr, size, addr, wdata), owner=1, go ADDR. Else if inst_req -> latch inst_addr, wr=0, size=2, wdata=0, owner=0, go ADDR. Else stay.
- Fixed priority: data over inst when both requested in same IDLE cycle.
- ADDR: bus_req=1 with latched fields; on bus_addr_ok go WAIT (bus_req low from WAIT on).
- WAIT: on bus_data_ok latch bus_rdata into return register (zero for writes), go DONE.
- DONE: assert owner's ok for exactly this cycle with registered rdata; unowned ok stays 0; go IDLE.
- Only one transaction outstanding; new requests ignored outside IDLE.
- bus_addr_ok in IDLE/WAIT/DONE and bus_data_ok outside WAIT are ignored.
- inst_rdata and data_rdata both drive the return register; only the ok pulse qualifies them.
- Requester changes its inputs only after sampling ok=1; requester inputs during ADDR..DONE do not affect the latched transaction.

## Timing
- Reset values: state=IDLE, owner=0, bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wdata=0, return register=0, inst_ok=0, data_ok=0. stall_f/stall_m follow inputs combinationally (high if req asserted during reset).
- Minimum latency: req seen in IDLE at cycle 0; bus_req cycle 1 (addr_ok same cycle); bus_data_ok cycle 2; ok pulse cycle 3; IDLE cycle 4. Each extra addr_ok or data_ok wait cycle adds one cycle.
- Back-to-back: losing requester is granted in the IDLE cycle after DONE.
- bus_req, bus_* and ok are registered outputs (no combinational path from bus inputs).
- Reset mid-transaction (any state): immediate return to IDLE, bus_req=0, no ok pulse. The bus is reset by the same signal, so no stale responses arrive.

## Test plan
- Single load: data_req=1, data_addr=0x8000_0004, addr_ok cycle 1, data_ok+rdata=0x1234_5678 cycle 2 -> data_ok=1 with data_rdata=0x1234_5678 in cycle 3 only; stall_m high cycles 0-2.
- Simultaneous: inst_req and data_req in cycle 0 -> data served first (bus_addr=data_addr); inst bus_req starts cycle 5, inst_ok cycle 7 with no wait states.
- Wait states: store word with addr_ok delayed 3 cycles and data_ok delayed 2 -> bus fields stable during ADDR; data_ok pulse 1 cycle after bus_data_ok; data_rdata=0.
- Spurious bus signals: bus_data_ok pulsed in IDLE and in ADDR -> no state change, no ok pulse.
- Byte store: data_size=0, addr=0x...03 -> bus_size=0, bus_addr=0x...03, wdata passed unchanged.
- Reset asserted during WAIT -> bus_req and all outputs reset asynchronously; after release, a new inst fetch completes normally with minimum latency.
